plot_arbiter: RTL and testbench

Owns the single pixel-write port of the VGA adapter and shares it between three requesters: screen clear, player sprite and CPU sprite. Requests are one-cycle pulses carrying an origin and colour. The arbiter latches each request, picks a winner and rasterises either a SPRITE_SIZE x SPRITE_SIZE block or a full-screen clear. It drives x/y/colour/plot one pixel per clock.

---
 rtl/plot_pkg.sv | 25 ++
 rtl/plot_raster_counter.sv | 47 ++++
 rtl/plot_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_plot_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/plot_pkg.sv
// Shared types and constants for the plot arbiter: FSM states, requester IDs,
// screen defaults and colour constants.
package plot_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAW  = 3'd2,
        S_SWEEP = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        REQ_CLR = 2'd0,
        REQ_PLY = 2'd1,
        REQ_CPU = 2'd2
    } req_id_t;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;

endpackage

// File: rtl/plot_raster_counter.sv
// 2-D raster counter, x fastest, with runtime extents. Used for sprite blocks
// and full-screen sweeps; last flags the final pixel of the raster.
module plot_raster_counter #(
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          advance,
    input  logic [XW-1:0] width,
    input  logic [YW-1:0] height,
    output logic [XW-1:0] cx,
    output logic [YW-1:0] cy,
    output logic          last
);

    logic [XW-1:0] cx_reg;
    logic [YW-1:0] cy_reg;
    logic          x_end;
    logic          y_end;

    assign x_end = (cx_reg == width - XW'(1));
    assign y_end = (cy_reg == height - YW'(1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cx_reg <= '0;
            cy_reg <= '0;
        end else if (start) begin
            cx_reg <= '0;
            cy_reg <= '0;
        end else if (advance) begin
            if (x_end) begin
                cx_reg <= '0;
                cy_reg <= y_end ? '0 : cy_reg + YW'(1);
            end else begin
                cx_reg <= cx_reg + XW'(1);
            end
        end
    end

    assign cx   = cx_reg;
    assign cy   = cy_reg;
    assign last = x_end && y_end;

endmodule

// File: rtl/plot_arbiter.sv
// Shares the VGA adapter pixel port between screen clear, player sprite and
// CPU sprite; rasterises the granted job one pixel per clock.
module plot_arbiter
    import plot_pkg::*;
#(
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int SCREEN_H    = SCREEN_H_DEF,
    parameter int SPRITE_SIZE = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear_req,
    input  logic [2:0] clear_colour,
    input  logic       p_req,
    input  logic [7:0] p_x,
    input  logic [6:0] p_y,
    input  logic [2:0] p_colour,
    input  logic       c_req,
    input  logic [7:0] c_x,
    input  logic [6:0] c_y,
    input  logic [2:0] c_colour,
    output logic       clear_done,
    output logic       p_done,
    output logic       c_done,
    output logic       busy,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    state_t     state_reg, state_next;
    req_id_t    win, gnt_reg;
    logic       grant;
    logic       rr_cpu_reg;
    logic [7:0] act_x_reg;
    logic [6:0] act_y_reg;
    logic [2:0] act_col_reg;

    logic [2:0] req_vec;
    logic [7:0] req_x   [3];
    logic [6:0] req_y   [3];
    logic [2:0] req_col [3];
    logic [2:0] pend;
    logic [7:0] pend_x  [3];
    logic [6:0] pend_y  [3];
    logic [2:0] pend_col[3];

    assign req_vec    = {c_req, p_req, clear_req};
    assign req_x[0]   = '0;
    assign req_x[1]   = p_x;
    assign req_x[2]   = c_x;
    assign req_y[0]   = '0;
    assign req_y[1]   = p_y;
    assign req_y[2]   = c_y;
    assign req_col[0] = clear_colour;
    assign req_col[1] = p_colour;
    assign req_col[2] = c_colour;

    // Clear always wins; between sprites, the one not served last goes first.
    always_comb begin
        win = REQ_CPU;
        if (pend[0])
            win = REQ_CLR;
        else if (pend[1] && (!pend[2] || !rr_cpu_reg))
            win = REQ_PLY;
    end

    assign grant = (state_reg == S_IDLE) && (|pend);

    for (genvar gi = 0; gi < 3; gi++) begin : g_req
        logic       flag_reg;
        logic [7:0] x_reg;
        logic [6:0] y_reg;
        logic [2:0] col_reg;
        logic       flush;

        // A fresh request in the same cycle survives both grant and clear flush.
        assign flush = (grant && (win == req_id_t'(2'(gi)))) ||
                       ((gi != 0) && (state_reg == S_LOAD) && (gnt_reg == REQ_CLR));

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                flag_reg <= 1'b0;
                x_reg    <= '0;
                y_reg    <= '0;
                col_reg  <= BLACK;
            end else if (req_vec[gi]) begin
                flag_reg <= 1'b1;
                x_reg    <= req_x[gi];
                y_reg    <= req_y[gi];
                col_reg  <= req_col[gi];
            end else if (flush) begin
                flag_reg <= 1'b0;
            end
        end

        assign pend[gi]     = flag_reg;
        assign pend_x[gi]   = x_reg;
        assign pend_y[gi]   = y_reg;
        assign pend_col[gi] = col_reg;
    end

    // Operands are snapshotted at grant so a new request cannot alter the job in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gnt_reg     <= REQ_CLR;
            act_x_reg   <= '0;
            act_y_reg   <= '0;
            act_col_reg <= BLACK;
            rr_cpu_reg  <= 1'b0;
        end else if (grant) begin
            gnt_reg     <= win;
            act_x_reg   <= pend_x[win];
            act_y_reg   <= pend_y[win];
            act_col_reg <= pend_col[win];
            if (win == REQ_PLY)
                rr_cpu_reg <= 1'b1;
            else if (win == REQ_CPU)
                rr_cpu_reg <= 1'b0;
        end
    end

    logic [7:0] ext_w, cx;
    logic [6:0] ext_h, cy;
    logic       last;

    assign ext_w = (gnt_reg == REQ_CLR) ? 8'(SCREEN_W) : 8'(SPRITE_SIZE);
    assign ext_h = (gnt_reg == REQ_CLR) ? 7'(SCREEN_H) : 7'(SPRITE_SIZE);

    plot_raster_counter #(.XW(8), .YW(7)) u_raster (
        .clk     (clk),
        .resetn  (resetn),
        .start   (state_reg == S_LOAD),
        .advance ((state_reg == S_DRAW) || (state_reg == S_SWEEP)),
        .width   (ext_w),
        .height  (ext_h),
        .cx      (cx),
        .cy      (cy),
        .last    (last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_reg <= S_IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (grant) state_next = S_LOAD;
            S_LOAD:  state_next = (gnt_reg == REQ_CLR) ? S_SWEEP : S_DRAW;
            S_DRAW,
            S_SWEEP: if (last) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    logic [7:0] x_next, x_reg;
    logic [6:0] y_next, y_reg;
    logic [2:0] colour_next, colour_reg;
    logic [2:0] done_next, done_reg;
    logic       plot_next, plot_reg, busy_next, busy_reg;
    logic [8:0] sum_x;
    logic [7:0] sum_y;

    // Sums are one bit wider than the screen coordinates so clipping never wraps.
    always_comb begin
        x_next      = '0;
        y_next      = '0;
        colour_next = BLACK;
        plot_next   = 1'b0;
        done_next   = '0;
        busy_next   = (state_next != S_IDLE);
        sum_x       = {1'b0, act_x_reg} + {1'b0, cx};
        sum_y       = {1'b0, act_y_reg} + {1'b0, cy};
        case (state_reg)
            S_DRAW: begin
                x_next      = sum_x[7:0];
                y_next      = sum_y[6:0];
                colour_next = act_col_reg;
                plot_next   = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
            end
            S_SWEEP: begin
                x_next      = cx;
                y_next      = cy;
                colour_next = act_col_reg;
                plot_next   = 1'b1;
            end
            S_DONE:  done_next = 3'b001 << gnt_reg;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_reg      <= '0;
            y_reg      <= '0;
            colour_reg <= BLACK;
            plot_reg   <= 1'b0;
            done_reg   <= '0;
            busy_reg   <= 1'b0;
        end else begin
            x_reg      <= x_next;
            y_reg      <= y_next;
            colour_reg <= colour_next;
            plot_reg   <= plot_next;
            done_reg   <= done_next;
            busy_reg   <= busy_next;
        end
    end

    assign x          = x_reg;
    assign y          = y_reg;
    assign colour     = colour_reg;
    assign plot       = plot_reg;
    assign busy       = busy_reg;
    assign clear_done = done_reg[0];
    assign p_done     = done_reg[1];
    assign c_done     = done_reg[2];

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed + randomized bench for plot_arbiter: a pixel-list reference model
// predicts every plotted pixel and done pulse per scenario.
module tb_plot_arbiter;
    import plot_pkg::*;

    localparam int SW  = 160;
    localparam int SH  = 120;
    localparam int SPR = 4;
    localparam int K_CLR = 0;
    localparam int K_PLY = 1;
    localparam int K_CPU = 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       clear_req = 1'b0, p_req = 1'b0, c_req = 1'b0;
    logic [2:0] clear_colour = '0, p_colour = '0, c_colour = '0;
    logic [7:0] p_x = '0, c_x = '0;
    logic [6:0] p_y = '0, c_y = '0;
    logic       clear_done, p_done, c_done, busy, plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    always #5 clk = ~clk;

    plot_arbiter dut (
        .clk(clk), .resetn(resetn),
        .clear_req(clear_req), .clear_colour(clear_colour),
        .p_req(p_req), .p_x(p_x), .p_y(p_y), .p_colour(p_colour),
        .c_req(c_req), .c_x(c_x), .c_y(c_y), .c_colour(c_colour),
        .clear_done(clear_done), .p_done(p_done), .c_done(c_done), .busy(busy),
        .x(x), .y(y), .colour(colour), .plot(plot)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_plot_cyc = -1;
    int last_plot_cyc = -1;
    int last_served = K_CPU;
    int req_cyc = 0;
    logic [17:0] obs_pix[$];
    logic [17:0] exp_pix[$];
    int done_kind[$], exp_done[$], done_cyc[$], done_gap[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (resetn) begin
            if (plot) begin
                obs_pix.push_back({x, y, colour});
                if (first_plot_cyc < 0) first_plot_cyc = cyc;
                last_plot_cyc = cyc;
            end
            if (clear_done) begin done_kind.push_back(K_CLR); done_cyc.push_back(cyc); done_gap.push_back(cyc - last_plot_cyc); end
            if (p_done)     begin done_kind.push_back(K_PLY); done_cyc.push_back(cyc); done_gap.push_back(cyc - last_plot_cyc); end
            if (c_done)     begin done_kind.push_back(K_CPU); done_cyc.push_back(cyc); done_gap.push_back(cyc - last_plot_cyc); end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        req_cyc = cyc + 1;
        tick(1);
        clear_req = 1'b0;
        p_req = 1'b0;
        c_req = 1'b0;
    endtask

    // Reference: a sprite is the SPR x SPR block at its origin minus off-screen pixels.
    task automatic model_sprite(input int kind, input int ox, input int oy, input int col);
        for (int dy = 0; dy < SPR; dy++)
            for (int dx = 0; dx < SPR; dx++)
                if (ox + dx < SW && oy + dy < SH)
                    exp_pix.push_back({8'(ox + dx), 7'(oy + dy), 3'(col)});
        exp_done.push_back(kind);
        last_served = kind;
    endtask

    task automatic model_clear(input int col);
        for (int yy = 0; yy < SH; yy++)
            for (int xx = 0; xx < SW; xx++)
                exp_pix.push_back({8'(xx), 7'(yy), 3'(col)});
        exp_done.push_back(K_CLR);
    endtask

    task automatic model_pair();
        if (last_served == K_PLY) begin
            model_sprite(K_CPU, int'(c_x), int'(c_y), int'(c_colour));
            model_sprite(K_PLY, int'(p_x), int'(p_y), int'(p_colour));
        end else begin
            model_sprite(K_PLY, int'(p_x), int'(p_y), int'(p_colour));
            model_sprite(K_CPU, int'(c_x), int'(c_y), int'(c_colour));
        end
    endtask

    task automatic clear_obs();
        obs_pix.delete(); exp_pix.delete();
        done_kind.delete(); exp_done.delete(); done_cyc.delete(); done_gap.delete();
        first_plot_cyc = -1;
        last_plot_cyc = -1;
    endtask

    task automatic wait_dones(input string tag, input int n, input int budget);
        int k = 0;
        while (done_kind.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        chk({tag, " done_in_time"}, 32'(done_kind.size() >= n), 1);
        tick(40);
        chk({tag, " busy_after"}, 32'(busy), 0);
    endtask

    task automatic wait_first_plot(input string tag);
        int k = 0;
        while (first_plot_cyc < 0 && k < 20) begin
            tick(1);
            k++;
        end
        chk({tag, " plot_started"}, 32'(first_plot_cyc >= 0), 1);
    endtask

    task automatic check_scenario(input string tag);
        int mis = -1;
        int n;
        chk({tag, " npix"}, obs_pix.size(), exp_pix.size());
        n = (obs_pix.size() < exp_pix.size()) ? obs_pix.size() : exp_pix.size();
        for (int i = 0; i < n; i++)
            if (obs_pix[i] !== exp_pix[i] && mis < 0) mis = i;
        chk({tag, " first_bad_pixel"}, mis, -1);
        chk({tag, " ndone"}, done_kind.size(), exp_done.size());
        for (int i = 0; i < done_kind.size() && i < exp_done.size(); i++)
            chk($sformatf("%s done%0d", tag, i), done_kind[i], exp_done[i]);
        $display("scenario %s: pixels=%0d dones=%0d", tag, obs_pix.size(), done_kind.size());
        clear_obs();
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst x", 32'(x), 0);
        chk("rst y", 32'(y), 0);
        chk("rst colour", 32'(colour), 0);
        chk("rst plot", 32'(plot), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst clear_done", 32'(clear_done), 0);
        chk("rst p_done", 32'(p_done), 0);
        chk("rst c_done", 32'(c_done), 0);
        resetn = 1'b1;
        tick(2);
        chk("post_rst busy", 32'(busy), 0);
        clear_obs();

        // Simultaneous after reset: player first
        p_x = 8'($urandom_range(0, 150)); p_y = 7'($urandom_range(0, 110)); p_colour = 3'($urandom_range(0, 7));
        c_x = 8'($urandom_range(0, 150)); c_y = 7'($urandom_range(0, 110)); c_colour = 3'($urandom_range(0, 7));
        p_req = 1'b1; c_req = 1'b1;
        model_pair();
        pulse();
        wait_dones("pair1", 2, 200);
        check_scenario("pair1");

        // Fixed player sprite with latency checks
        p_x = 8'd10; p_y = 7'd20; p_colour = 3'b100; p_req = 1'b1;
        model_sprite(K_PLY, 10, 20, 4);
        pulse();
        wait_dones("player", 1, 100);
        chk("player first_plot_latency", first_plot_cyc - req_cyc, 3);
        chk("player done_gap", (done_gap.size() > 0) ? done_gap[0] : -1, 1);
        check_scenario("player");

        // Simultaneous again with player served last: CPU first
        p_x = 8'($urandom_range(0, 159)); p_y = 7'($urandom_range(0, 119)); p_colour = 3'($urandom_range(0, 7));
        c_x = 8'($urandom_range(0, 159)); c_y = 7'($urandom_range(0, 119)); c_colour = 3'($urandom_range(0, 7));
        p_req = 1'b1; c_req = 1'b1;
        model_pair();
        pulse();
        wait_dones("pair2", 2, 200);
        check_scenario("pair2");

        // Randomized solo sprites, often near the edges
        for (int i = 0; i < 4; i++) begin
            int kind, ox, oy, col;
            kind = $urandom_range(1, 2);
            ox = $urandom_range(0, 1) ? $urandom_range(150, 159) : $urandom_range(0, 159);
            oy = $urandom_range(0, 1) ? $urandom_range(112, 119) : $urandom_range(0, 119);
            col = $urandom_range(0, 7);
            if (kind == K_PLY) begin
                p_x = 8'(ox); p_y = 7'(oy); p_colour = 3'(col); p_req = 1'b1;
            end else begin
                c_x = 8'(ox); c_y = 7'(oy); c_colour = 3'(col); c_req = 1'b1;
            end
            model_sprite(kind, ox, oy, col);
            pulse();
            wait_dones($sformatf("solo%0d", i), 1, 100);
            check_scenario($sformatf("solo%0d", i));
        end

        // Clear arrives during CPU draw; pending player is flushed by the clear
        c_x = 8'($urandom_range(0, 150)); c_y = 7'($urandom_range(0, 110)); c_colour = 3'($urandom_range(0, 7));
        c_req = 1'b1;
        model_sprite(K_CPU, int'(c_x), int'(c_y), int'(c_colour));
        pulse();
        wait_first_plot("clear");
        clear_colour = WHITE; clear_req = 1'b1;
        p_x = 8'($urandom_range(0, 150)); p_y = 7'($urandom_range(0, 110)); p_colour = 3'($urandom_range(0, 7));
        p_req = 1'b1;
        model_clear(int'(WHITE));
        pulse();
        wait_dones("clear", 2, 20000);
        chk("clear done_gap", (done_gap.size() > 1) ? done_gap[1] : -1, 1);
        check_scenario("clear");

        // Clipped sprite at the bottom-right corner
        c_x = 8'd158; c_y = 7'd118; c_colour = 3'($urandom_range(0, 7)); c_req = 1'b1;
        model_sprite(K_CPU, 158, 118, int'(c_colour));
        pulse();
        wait_dones("clip", 1, 100);
        chk("clip done_time", (done_cyc.size() > 0) ? done_cyc[0] - req_cyc : -1, 3 + SPR * SPR);
        check_scenario("clip");

        // Asynchronous reset mid-draw with another request pending
        c_x = 8'($urandom_range(0, 150)); c_y = 7'($urandom_range(0, 110)); c_colour = 3'($urandom_range(0, 7));
        c_req = 1'b1;
        pulse();
        wait_first_plot("midrst");
        p_x = 8'($urandom_range(0, 150)); p_y = 7'($urandom_range(0, 110)); p_req = 1'b1;
        pulse();
        resetn = 1'b0;
        #1;
        chk("midrst plot", 32'(plot), 0);
        chk("midrst busy", 32'(busy), 0);
        chk("midrst c_done", 32'(c_done), 0);
        tick(3);
        resetn = 1'b1;
        clear_obs();
        last_served = K_CPU;
        tick(50);
        chk("midrst stale_pixels", obs_pix.size(), 0);
        chk("midrst stale_dones", done_kind.size(), 0);
        chk("midrst busy_after", 32'(busy), 0);

        // Pointer returns to favouring the player after reset
        p_x = 8'($urandom_range(0, 159)); p_y = 7'($urandom_range(0, 119)); p_colour = 3'($urandom_range(0, 7));
        c_x = 8'($urandom_range(0, 159)); c_y = 7'($urandom_range(0, 119)); c_colour = 3'($urandom_range(0, 7));
        p_req = 1'b1; c_req = 1'b1;
        model_pair();
        pulse();
        wait_dones("pair3", 2, 200);
        check_scenario("pair3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
